// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one line-wide memory port between the I-cache (port 0)
// and D-cache (port 1). Optional BUSY timeout with sticky err_o via `define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 256,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic [DATA_W-1:0] p0_data_o,
    output logic              p0_ack_o,
    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              p1_ack_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [1:0]        grant_o,
    output logic              err_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    state_t      state;
    logic        last_grant;
    logic        any_req;
    logic        pick;
    req_t [1:0]  req;
    req_t        win;

    assign req[0] = '{write: p0_write_i, addr: p0_addr_i, data: p0_data_i};
    assign req[1] = '{write: p1_write_i, addr: p1_addr_i, data: p1_data_i};

    // On a tie the port that did not win last time goes first.
    always_comb begin
        any_req = p0_enable_i | p1_enable_i;
        pick    = (p0_enable_i & p1_enable_i) ? ~last_grant : p1_enable_i;
        win     = req[pick];
    end

    // grant_o is only non-zero in BUSY, so memory acks in IDLE/DONE never reach a port.
    logic [1:0]             port_ack;
    logic [1:0][DATA_W-1:0] port_rdata;

    for (genvar g = 0; g < 2; g++) begin : g_rsp
        assign port_ack[g]   = mem_ack_i & grant_o[g];
        assign port_rdata[g] = port_ack[g] ? mem_data_i : '0;
    end

    assign p0_ack_o  = port_ack[0];
    assign p1_ack_o  = port_ack[1];
    assign p0_data_o = port_rdata[0];
    assign p1_data_o = port_rdata[1];

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt;
`else
    // Timeout length has no effect in this build.
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign err_o      = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            grant_o      <= 2'b00;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt      <= '0;
            err_o        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        mem_enable_o <= 1'b1;
                        mem_write_o  <= win.write;
                        mem_addr_o   <= win.addr;
                        mem_data_o   <= win.data;
                        grant_o      <= pick ? 2'b10 : 2'b01;
                        last_grant   <= pick;
                        state        <= BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                        tmo_cnt      <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        mem_enable_o <= 1'b0;
                        grant_o      <= 2'b00;
                        state        <= DONE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        // Abandon the access without acking; the requester retries.
                        mem_enable_o <= 1'b0;
                        grant_o      <= 2'b00;
                        err_o        <= 1'b1;
                        state        <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 256;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_enable_i, p0_write_i, p1_enable_i, p1_write_i;
    logic [AW-1:0] p0_addr_i, p1_addr_i;
    logic [DW-1:0] p0_data_i, p1_data_i, p0_data_o, p1_data_o;
    logic          p0_ack_o, p1_ack_o;
    logic          mem_enable_o, mem_write_o, mem_ack_i, err_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o, mem_data_i;
    logic [1:0]    grant_o;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
        .p0_data_i(p0_data_i), .p0_data_o(p0_data_o), .p0_ack_o(p0_ack_o),
        .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
        .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_ack_o(p1_ack_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .grant_o(grant_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_en(input string nm);
        int n = 0;
        while (mem_enable_o !== 1'b1 && n < 50) begin
            step(1);
            n++;
        end
        chk(nm, DW'(mem_enable_o), DW'(1'b1));
    endtask

    // Model: who owns memory (-1 none), a one-cycle gap after each completion,
    // and which port wins the next tie.
    int            own      = -1;
    bit            gap      = 1'b0;
    int            pref     = 0;
    int            busy_cyc = 0;
    bit            m_err    = 1'b0;
    logic          m_w      = 1'b0;
    logic [AW-1:0] m_a      = '0;
    logic [DW-1:0] m_d      = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            own = -1; gap = 1'b0; pref = 0; m_err = 1'b0;
            m_w = 1'b0; m_a = '0; m_d = '0;
        end else if (own >= 0) begin
            busy_cyc++;
            if (mem_ack_i) begin
                own = -1; gap = 1'b1;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (busy_cyc >= TO) begin
                own = -1; gap = 1'b1; m_err = 1'b1;
            end
`endif
        end else if (gap) begin
            gap = 1'b0;
        end else if (p0_enable_i || p1_enable_i) begin
            own      = (p0_enable_i && p1_enable_i) ? pref : (p0_enable_i ? 0 : 1);
            pref     = 1 - own;
            busy_cyc = 0;
            if (own == 0) begin m_w = p0_write_i; m_a = p0_addr_i; m_d = p0_data_i; end
            else          begin m_w = p1_write_i; m_a = p1_addr_i; m_d = p1_data_i; end
        end
    end

    always @(negedge clk) begin : cmp
        logic [1:0] eg;
        logic       ea0, ea1;
        eg  = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
        ea0 = mem_ack_i && own == 0;
        ea1 = mem_ack_i && own == 1;
        chk("mdl_mem_enable", DW'(mem_enable_o), DW'(own >= 0));
        chk("mdl_grant", DW'(grant_o), DW'(eg));
        chk("mdl_mem_write", DW'(mem_write_o), DW'(m_w));
        chk("mdl_mem_addr", DW'(mem_addr_o), DW'(m_a));
        chk("mdl_mem_data", mem_data_o, m_d);
        chk("mdl_err", DW'(err_o), DW'(m_err));
        chk("mdl_p0_ack", DW'(p0_ack_o), DW'(ea0));
        chk("mdl_p1_ack", DW'(p1_ack_o), DW'(ea1));
        chk("mdl_p0_data", p0_data_o, ea0 ? mem_data_i : '0);
        chk("mdl_p1_data", p1_data_o, ea1 ? mem_data_i : '0);
    end

    logic [DW-1:0] line1, pat_a5;

    initial begin
        p0_enable_i = 0; p0_write_i = 0; p0_addr_i = '0; p0_data_i = '0;
        p1_enable_i = 0; p1_write_i = 0; p1_addr_i = '0; p1_data_i = '0;
        mem_ack_i = 0; mem_data_i = '0;
        line1  = {8{32'hDEAD_0400}};
        pat_a5 = {32{8'hA5}};

        // Reset state
        step(2);
        chk("rst_mem_enable", DW'(mem_enable_o), '0);
        chk("rst_grant", DW'(grant_o), '0);
        chk("rst_err", DW'(err_o), '0);
        chk("rst_mem_addr", DW'(mem_addr_o), '0);
        rst = 1'b0;

        // Single read on port 1
        step(1);
        p1_enable_i = 1; p1_write_i = 0; p1_addr_i = 32'h0000_0400;
        step(1);
        chk("t1_en_next_cycle", DW'(mem_enable_o), DW'(1'b1));
        chk("t1_grant", DW'(grant_o), DW'(2'b10));
        chk("t1_addr", DW'(mem_addr_o), DW'(32'h400));
        step(9);
        mem_ack_i = 1; mem_data_i = line1;
        #1;
        chk("t1_p1_ack", DW'(p1_ack_o), DW'(1'b1));
        chk("t1_p1_data", p1_data_o, line1);
        chk("t1_p0_ack", DW'(p0_ack_o), '0);
        step(1);
        mem_ack_i = 0; mem_data_i = '0; p1_enable_i = 0;
        chk("t1_done_gap", DW'(mem_enable_o), '0);
        chk("t1_ack_pulse_end", DW'(p1_ack_o), '0);
        step(2);

        // Memory ack while idle
        mem_ack_i = 1; mem_data_i = line1;
        #1;
        chk("t4_p0_ack_idle", DW'(p0_ack_o), '0);
        chk("t4_p1_ack_idle", DW'(p1_ack_o), '0);
        chk("t4_p1_data_idle", p1_data_o, '0);
        step(1);
        mem_ack_i = 0; mem_data_i = '0;
        chk("t4_stay_idle", DW'(mem_enable_o), '0);

        // Both ports request from reset release: grants alternate 0,1,0,1
        rst = 1'b1;
        p0_enable_i = 1; p0_addr_i = 32'h1000;
        p1_enable_i = 1; p1_addr_i = 32'h2000;
        step(1);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_en("t2_en");
            chk("t2_grant_order", DW'(grant_o), DW'((k % 2 == 0) ? 2'b01 : 2'b10));
            chk("t2_addr", DW'(mem_addr_o), DW'((k % 2 == 0) ? 32'h1000 : 32'h2000));
            step(2);
            mem_ack_i = 1; mem_data_i = DW'(k + 1);
            step(1);
            mem_ack_i = 0; mem_data_i = '0;
        end
        p0_enable_i = 0; p1_enable_i = 0;
        step(2);

        // Port 0 write held stable while port 1 changes its address
        p0_enable_i = 1; p0_write_i = 1; p0_addr_i = 32'h40; p0_data_i = pat_a5;
        p1_enable_i = 1; p1_write_i = 0; p1_addr_i = 32'h800;
        wait_en("t3_en");
        chk("t3_grant", DW'(grant_o), DW'(2'b01));
        chk("t3_write", DW'(mem_write_o), DW'(1'b1));
        step(1);
        p1_addr_i = 32'h900; p0_data_i = ~pat_a5;
        step(2);
        chk("t3_addr_hold", DW'(mem_addr_o), DW'(32'h40));
        chk("t3_data_hold", mem_data_o, pat_a5);
        mem_ack_i = 1; mem_data_i = line1;
        #1;
        chk("t3_p0_ack", DW'(p0_ack_o), DW'(1'b1));
        chk("t3_p1_ack", DW'(p1_ack_o), '0);
        step(1);
        p0_enable_i = 0; p0_write_i = 0;
        #1;
        chk("t3_ack_in_done", DW'(p0_ack_o), '0);
        step(1);
        mem_ack_i = 0; mem_data_i = '0;
        wait_en("t3_p1_en");
        chk("t3_p1_grant", DW'(grant_o), DW'(2'b10));
        chk("t3_p1_addr", DW'(mem_addr_o), DW'(32'h900));
        step(1);
        mem_ack_i = 1; mem_data_i = ~line1;
        #1;
        chk("t3_p1_data", p1_data_o, ~line1);
        step(1);
        mem_ack_i = 0; mem_data_i = '0; p1_enable_i = 0;
        step(2);

        // Async reset three cycles into BUSY
        p0_enable_i = 1; p0_addr_i = 32'h1000;
        p1_enable_i = 1; p1_addr_i = 32'h2000;
        wait_en("t5_en");
        step(2);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_en", DW'(mem_enable_o), '0);
        chk("t5_async_grant", DW'(grant_o), '0);
        step(1);
        rst = 1'b0;
        wait_en("t5_re_en");
        chk("t5_p0_first", DW'(grant_o), DW'(2'b01));
        step(1);
        mem_ack_i = 1;
        step(1);
        mem_ack_i = 0; p0_enable_i = 0;
        wait_en("t5_p1_en");
        chk("t5_p1_next", DW'(grant_o), DW'(2'b10));
        mem_ack_i = 1;
        step(1);
        mem_ack_i = 0; p1_enable_i = 0;
        step(2);

        // Memory never acks
        p0_enable_i = 1; p0_addr_i = 32'h80;
        wait_en("t6_en");
`ifdef MEM_ARB_TIMEOUT_EN
        begin : t6_tmo
            int n;
            n = 1;
            while (mem_enable_o === 1'b1 && n < 40) begin
                step(1);
                if (mem_enable_o === 1'b1) n++;
            end
            chk("t6_busy_cycles", DW'(n), DW'(TO));
            chk("t6_err_set", DW'(err_o), DW'(1'b1));
            chk("t6_no_ack", DW'(p0_ack_o), '0);
            step(3);
            chk("t6_err_sticky", DW'(err_o), DW'(1'b1));
        end
`else
        step(20);
        chk("t6_still_busy", DW'(mem_enable_o), DW'(1'b1));
        chk("t6_grant_held", DW'(grant_o), DW'(2'b01));
        chk("t6_err_zero", DW'(err_o), '0);
`endif
        p0_enable_i = 0;
        rst = 1'b1;
        step(1);
        chk("t6_err_cleared", DW'(err_o), '0);
        rst = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
